// File: rtl/bank_robin_arbiter.sv
// -----------------------------------------------------------------------------
// bank_robin_arbiter
//
// Round-robin arbiter that grants one bank to one of NUM_RD_PORTS read-port
// requesters. A port that wins keeps the bank for up to MAX_HOLD consecutive
// cycles while it keeps requesting. When its hold expires, or when it drops
// its request, the bank is re-arbitrated round-robin starting at the port
// after the last winner. The grant is combinational from req, so the address
// distributor can route the bank address in the request cycle itself.
//
// Parameters:
//   NUM_RD_PORTS  number of requesters on the bank (2..8)
//   MAX_HOLD      max consecutive cycles one port keeps the bank while it
//                 keeps requesting (1..15); 1 gives plain per-cycle round robin
//   IDX_W         port index width, derived from NUM_RD_PORTS
//
// Ports:
//   clk        clock; all state updates on the rising edge
//   rst_n      synchronous active-low reset; also blanks the grant outputs
//   req        per-port request
//   gnt        per-port grant, one-hot or zero
//   gnt_valid  high when any gnt bit is high
//   gnt_idx    index of the granted port, 0 when no grant
// -----------------------------------------------------------------------------
module bank_robin_arbiter #(
  parameter int NUM_RD_PORTS = 8,
  parameter int MAX_HOLD     = 4,
  parameter int IDX_W        = $clog2(NUM_RD_PORTS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_RD_PORTS-1:0] req,
  output logic [NUM_RD_PORTS-1:0] gnt,
  output logic                    gnt_valid,
  output logic [IDX_W-1:0]        gnt_idx
);

  // Arbitration state
  logic [IDX_W-1:0] ptr_q,       ptr_d;        // first port searched
  logic [IDX_W-1:0] owner_q,     owner_d;      // current holder of the bank
  logic             owner_vld_q, owner_vld_d;
  logic [3:0]       hold_cnt_q,  hold_cnt_d;   // cycles granted to owner so far

  // Decision signals
  logic             cont;        // owner keeps the bank this cycle
  logic             sel_found;   // some port requests
  logic [IDX_W-1:0] sel_idx;     // round-robin winner from ptr_q
  logic [IDX_W-1:0] sel_nxt;     // port after sel_idx, wrapping at NUM_RD_PORTS
  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Owner continues only while requesting and short of its hold limit. After a
  // selection ptr_q already points at owner+1, so an expired hold searches from
  // the port after the owner without any extra logic.
  assign cont = owner_vld_q && req[owner_q] && (hold_cnt_q < 4'(MAX_HOLD));

  // Round-robin search ptr, ptr+1, ... modulo NUM_RD_PORTS. The wrap is done
  // explicitly rather than by bit truncation so non-power-of-two port counts
  // never produce an index >= NUM_RD_PORTS.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < NUM_RD_PORTS; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_RD_PORTS) cand = cand - NUM_RD_PORTS;
      cand_idx = IDX_W'(cand);
      if (!sel_found && req[cand_idx]) begin
        sel_found = 1'b1;
        sel_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    sel_nxt = '0;
    if (sel_idx != IDX_W'(NUM_RD_PORTS - 1)) sel_nxt = sel_idx + IDX_W'(1);
  end

  // Grant outputs; blanked while reset is asserted regardless of req.
  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (rst_n) begin
      if (cont) begin
        gnt[owner_q] = 1'b1;
        gnt_valid    = 1'b1;
        gnt_idx      = owner_q;
      end else if (sel_found) begin
        gnt[sel_idx] = 1'b1;
        gnt_valid    = 1'b1;
        gnt_idx      = sel_idx;
      end
    end
  end

  // Next state. hold_cnt_q only increments on a continue, which requires
  // hold_cnt_q < MAX_HOLD <= 15, so the 4-bit counter cannot wrap.
  always_comb begin
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    owner_vld_d = owner_vld_q;
    hold_cnt_d  = hold_cnt_q;
    if (cont) begin
      hold_cnt_d = hold_cnt_q + 4'd1;
    end else if (sel_found) begin
      owner_d     = sel_idx;
      owner_vld_d = 1'b1;
      hold_cnt_d  = 4'd1;
      ptr_d       = sel_nxt;
    end else begin
      owner_vld_d = 1'b0;
      hold_cnt_d  = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of the others, independent of statement order.
    if (!rst_n) begin
      ptr_q       <= '0;
      owner_q     <= '0;
      owner_vld_q <= 1'b0;
      hold_cnt_q  <= 4'd0;
    end else begin
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      owner_vld_q <= owner_vld_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

endmodule
